// File: rtl/osbm_if.sv
// Bus bundle between the input FIFOs, the output FIFO and one osbm output arbiter.
// `PORT normally comes from sw.vh; it defaults to 3 (four ports) when not already defined.
`ifndef PORT
`define PORT 3
`endif

interface osbm_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [`PORT:0]             req;
    logic [`PORT:0]             in_empty;
    logic [`PORT:0][1:0]        in_cmd;
    logic [`PORT:0][DATA_W-1:0] in_data;
    logic                       full;
    logic [`PORT:0]             ack;
    logic                       out_we;
    logic [1:0]                 out_cmd;
    logic [DATA_W-1:0]          out_data;
    logic [`PORT:0]             owner;
    logic [CNT_W-1:0]           pkt_cnt;

    modport slave (
        input  req, in_empty, in_cmd, in_data, full,
        output ack, out_we, out_cmd, out_data, owner, pkt_cnt
    );

    modport master (
        output req, in_empty, in_cmd, in_data, full,
        input  ack, out_we, out_cmd, out_data, owner, pkt_cnt
    );
endinterface

// File: rtl/osbm.sv
// Output-side switch arbiter: grants one input per packet and forwards its flits until the tail.
// Define OSBM_RR_EN for round-robin arbitration; otherwise fixed priority (lowest port wins).
module osbm #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    osbm_if.slave bus
);
    localparam int N = `PORT + 1;

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [`PORT:0]      owner_q, owner_d;
    logic                out_we_q, out_we_d;
    logic [1:0]          out_cmd_q, out_cmd_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

    logic [`PORT:0]      grant;
    logic [`PORT:0]      ack_w;
    logic                xfer;
    logic [1:0]          sel_cmd;
    logic [DATA_W-1:0]   sel_data;
    logic                found;

`ifdef OSBM_RR_EN
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    int               rr_idx;

    // Search begins at the pointer, which always names the port after the last winner.
    always_comb begin
        grant  = '0;
        ptr_d  = ptr_q;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 0; k < N; k++) begin
            rr_idx = (int'(ptr_q) + k) % N;
            if (!found && bus.req[rr_idx]) begin
                found         = 1'b1;
                grant[rr_idx] = 1'b1;
                ptr_d         = PTR_W'((rr_idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && found) begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        ack_w = '0;
        if (state_q == XFER) begin
            ack_w = owner_q & ~bus.in_empty & {N{~bus.full}};
        end
    end

    assign xfer = |ack_w;

    always_comb begin
        sel_cmd  = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (ack_w[i]) begin
                sel_cmd  = bus.in_cmd[i];
                sel_data = bus.in_data[i];
            end
        end
    end

    // NOTE: every variable gets a default before the case; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        pkt_cnt_d  = pkt_cnt_q;
        out_we_d   = xfer;
        out_cmd_d  = out_cmd_q;
        out_data_d = out_data_q;
        if (xfer) begin
            out_cmd_d  = sel_cmd;
            out_data_d = sel_data;
        end
        unique case (state_q)
            IDLE: begin
                owner_d = grant;
                if (found) state_d = XFER;
            end
            XFER: begin
                if (xfer && sel_cmd == 2'b11) begin
                    state_d   = RELEASE;
                    owner_d   = '0;
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            out_we_q   <= 1'b0;
            out_cmd_q  <= 2'b00;
            out_data_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            out_we_q   <= out_we_d;
            out_cmd_q  <= out_cmd_d;
            out_data_q <= out_data_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign bus.ack      = ack_w;
    assign bus.owner    = owner_q;
    assign bus.out_we   = out_we_q;
    assign bus.out_cmd  = out_cmd_q;
    assign bus.out_data = out_data_q;
    assign bus.pkt_cnt  = pkt_cnt_q;
endmodule
